// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: SPI_RAM opcodes, command/data widths and arbiter FSM state encoding
package spi_ram_pkg;
  localparam int CMD_W = 10;
  localparam int DATA_W = 8;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP1,
    S_DATA,
    S_GAP2,
    S_WAIT_RD,
    S_DONE
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search starts at ptr and wraps
//  req  in  NUM_REQ  request vector
//  ptr  in  IW       first index to consider
//  gnt  out NUM_REQ  one-hot winner (zero when no request)
//  idx  out IW       winner index
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);
  logic [IW:0] s;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      s = s >= (IW+1)'(NUM_REQ) ? s - (IW+1)'(NUM_REQ) : s;
      if (!found && req[s[IW-1:0]]) begin
        found = 1'b1;
        gnt[s[IW-1:0]] = 1'b1;
        idx = s[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin sharing of one SPI_RAM command port among NUM_REQ masters
//  clk, rst_n                      clock, async active-low reset
//  req/req_we/req_addr/req_wdata   per-requester transaction (flat, 8 bits per requester)
//  gnt, done, rdata, err           grant (grant..done), completion pulse, read data, timeout flag
//  ram_din, ram_rx_valid           {opcode, byte} command word and strobe to SPI_RAM
//  ram_dout, ram_tx_valid          SPI_RAM read data and valid
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [DATA_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic [CMD_W-1:0]          ram_din,
  output logic                      ram_rx_valid,
  input  logic [DATA_W-1:0]         ram_dout,
  input  logic                      ram_tx_valid
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  state_t state, state_n;
  logic we_q, we_n, err_n, rxv_n, sel_we;
  logic [DATA_W-1:0] wdata_q, wdata_n, rdata_n, sel_addr, sel_wdata;
  logic [IW-1:0] win_q, win_n, ptr, ptr_n, arb_idx;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_n, done_n, arb_gnt;
  logic [CMD_W-1:0] din_n;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  assign sel_we = req_we[arb_idx];
  assign sel_addr = req_addr[{arb_idx, 3'b000} +: DATA_W];
  assign sel_wdata = req_wdata[{arb_idx, 3'b000} +: DATA_W];
  // Outputs are computed one state ahead so each registered value is
  // visible during the state it belongs to.
  always_comb begin
    state_n = state;
    we_n = we_q;
    wdata_n = wdata_q;
    win_n = win_q;
    ptr_n = ptr;
    cnt_n = cnt;
    gnt_n = gnt;
    done_n = '0;
    err_n = 1'b0;
    rdata_n = rdata;
    din_n = ram_din;
    rxv_n = 1'b0;
    case (state)
      S_IDLE: if (|req) begin
        state_n = S_ADDR;
        we_n = sel_we;
        wdata_n = sel_wdata;
        win_n = arb_idx;
        gnt_n = arb_gnt;
        din_n = {sel_we ? CMD_WR_ADDR : CMD_RD_ADDR, sel_addr};
        rxv_n = 1'b1;
      end
      S_ADDR: state_n = S_GAP1;
      S_GAP1: begin
        state_n = S_DATA;
        din_n = {we_q ? CMD_WR_DATA : CMD_RD_DATA, we_q ? wdata_q : '0};
        rxv_n = 1'b1;
      end
      S_DATA: begin
        state_n = we_q ? S_GAP2 : S_WAIT_RD;
        cnt_n = '0;
      end
      S_GAP2: begin
        state_n = S_DONE;
        done_n[win_q] = 1'b1;
      end
      S_WAIT_RD: if (ram_tx_valid || cnt == CW'(TIMEOUT - 1)) begin
        state_n = S_DONE;
        done_n[win_q] = 1'b1;
        rdata_n = ram_tx_valid ? ram_dout : '0;
        err_n = !ram_tx_valid;
      end else cnt_n = cnt + CW'(1);
      S_DONE: begin
        state_n = S_IDLE;
        gnt_n = '0;
        ptr_n = win_q == IW'(NUM_REQ - 1) ? '0 : win_q + IW'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      we_q <= 1'b0;
      wdata_q <= '0;
      win_q <= '0;
      ptr <= '0;
      cnt <= '0;
      gnt <= '0;
      done <= '0;
      err <= 1'b0;
      rdata <= '0;
      ram_din <= '0;
      ram_rx_valid <= 1'b0;
    end else begin
      state <= state_n;
      we_q <= we_n;
      wdata_q <= wdata_n;
      win_q <= win_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      gnt <= gnt_n;
      done <= done_n;
      err <= err_n;
      rdata <= rdata_n;
      ram_din <= din_n;
      ram_rx_valid <= rxv_n;
    end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed and randomized transactions against a behavioural SPI_RAM and arbiter model
module tb_spi_ram_arbiter;
  localparam int N = 3;
  localparam int T = 6;
  typedef struct {int c; logic [9:0] w;} cmd_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, req_we = '0, gnt, done;
  logic [8*N-1:0] req_addr = '0, req_wdata = '0;
  logic [7:0] rdata, ram_dout = '0;
  logic err, ram_rx_valid, ram_tx_valid = 1'b0;
  logic [9:0] ram_din;
  int checks = 0, errors = 0;
  int cyc = 0, tx_at = -1, rd_d = 0, ptr_m = 0, done_c = 0;
  bit done_seen = 0, stray = 0, rxv_prev = 0, done_err = 0;
  logic [N-1:0] done_v, gnt_d;
  logic [7:0] done_rd, last_rd = '0, ram_a = '0;
  logic [7:0] ram_mem [256];
  logic [7:0] ref_mem [256];
  logic p_we [N];
  logic [7:0] p_addr [N];
  logic [7:0] p_wdata [N];
  cmd_t cmd_q [$];

  spi_ram_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .gnt(gnt),
    .done(done),
    .rdata(rdata),
    .err(err),
    .ram_din(ram_din),
    .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout),
    .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  task automatic pack(input int i);
    req_we[i] = p_we[i];
    req_addr[8*i +: 8] = p_addr[i];
    req_wdata[8*i +: 8] = p_wdata[i];
  endtask

  task automatic randp(input int i, input int mode);
    p_we[i] = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    p_addr[i] = 8'($urandom);
    p_wdata[i] = 8'($urandom);
    pack(i);
  endtask

  // One clock: observe outputs, play the SPI_RAM role, record completions.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
    chk("done_onehot", 32'($countones(done) <= 1), 1);
    if (ram_rx_valid) begin
      chk("rx_gap", rxv_prev, 0);
      cmd_q.push_back('{cyc, ram_din});
      case (ram_din[9:8])
        2'b00, 2'b10: ram_a = ram_din[7:0];
        2'b01: ram_mem[ram_a] = ram_din[7:0];
        default: tx_at = rd_d > 0 ? cyc + rd_d : -1;
      endcase
    end
    rxv_prev = ram_rx_valid;
    if (err) chk("err_with_done", 32'(|done), 1);
    if (|done && !done_seen) begin
      done_seen = 1;
      done_c = cyc;
      done_v = done;
      done_rd = rdata;
      done_err = err;
      gnt_d = gnt;
    end
    ram_tx_valid = cyc == tx_at || (stray && $urandom_range(0, 2) == 0);
    ram_dout = cyc == tx_at ? ram_mem[ram_a] : 8'($urandom);
  endtask

  // mode: 0 random, 1 writes only, 2 reads only; dm: 0 random read delay, <0 never, >0 fixed
  task automatic run(input logic [N-1:0] mask, input int ntx, input int mode, input int dm, input bit keep);
    int n, w, d, exp_c;
    bit we, to;
    logic [7:0] a, wd;
    step();
    for (int i = 0; i < N; i++) if (mask[i] && !keep) randp(i, mode);
    req = mask;
    n = cyc;
    for (int t = 0; t < ntx; t++) begin
      w = rr_pick(req, ptr_m);
      we = p_we[w];
      a = p_addr[w];
      wd = p_wdata[w];
      d = dm == 0 ? int'($urandom_range(1, T + 2)) : dm;
      to = !we && (d < 0 || d > T);
      rd_d = to ? 0 : d;
      cmd_q.delete();
      done_seen = 0;
      for (int k = 0; k < T + 20 && !done_seen; k++) step();
      chk("done_seen", 32'(done_seen), 1);
      exp_c = we ? n + 5 : to ? n + 4 + T : n + 4 + d;
      chk("done_cycle", done_c, exp_c);
      chk("done_vec", 32'(done_v), 32'(1 << w));
      chk("gnt_at_done", 32'(gnt_d), 32'(1 << w));
      chk("err", 32'(done_err), 32'(to));
      if (!we) last_rd = to ? 8'h00 : ref_mem[a];
      chk("rdata", 32'(done_rd), 32'(last_rd));
      chk("cmd_count", cmd_q.size(), 2);
      if (cmd_q.size() == 2) begin
        chk("cmd0_word", 32'(cmd_q[0].w), 32'({we ? 2'b00 : 2'b10, a}));
        chk("cmd0_cycle", cmd_q[0].c, n + 1);
        chk("cmd1_word", 32'(cmd_q[1].w), 32'({we ? 2'b01 : 2'b11, we ? wd : 8'h00}));
        chk("cmd1_cycle", cmd_q[1].c, n + 3);
      end
      if (we) ref_mem[a] = wd;
      ptr_m = (w + 1) % N;
      n = done_c + 1;
      if (t == ntx - 1) req = '0;
      else randp(w, mode);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      p_we[i] = 1'b0;
      p_addr[i] = '0;
      p_wdata[i] = '0;
    end
    step();
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rxv", 32'(ram_rx_valid), 0);
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst_n = 1'b1;
    p_we[0] = 1'b1;
    p_addr[0] = 8'h01;
    p_wdata[0] = 8'hFF;
    pack(0);
    run(3'b001, 1, 0, 0, 1);
    p_we[0] = 1'b0;
    pack(0);
    run(3'b001, 1, 0, 3, 1);
    for (int i = 0; i < 20; i++) run(3'(1 << $urandom_range(0, N - 1)), 1, 0, 0, 0);
    run(3'b011, 4, 1, 0, 0);
    run(3'b111, 9, 0, 0, 0);
    run(3'b101, 4, 0, 0, 0);
    p_we[0] = 1'b0;
    p_addr[0] = 8'($urandom);
    pack(0);
    run(3'b001, 1, 0, -1, 1);
    run(3'b010, 1, 1, 0, 0);
    stray = 1;
    for (int i = 0; i < 3; i++) run(3'($urandom_range(1, 7)), 2, 1, 0, 0);
    stray = 0;
    run(3'b001, 1, 1, 0, 0);
    step();
    p_we[1] = 1'b1;
    p_addr[1] = 8'($urandom);
    p_wdata[1] = 8'($urandom);
    pack(1);
    req = 3'b010;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_rxv", 32'(ram_rx_valid), 0);
    chk("mid_rst_din", 32'(ram_din), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    ptr_m = 0;
    last_rd = '0;
    rxv_prev = 0;
    cmd_q.delete();
    run(3'b011, 2, 1, 0, 0);
    run(3'b111, 6, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
